// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: sequential PC generation, 2-entry skid FIFO for the
// 1-cycle sync-read memory, branch redirects and arbitration with the program loader.
module imem_fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              load_req_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_gnt_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic [DATA_W-1:0] inst_data_o
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~{{(ADDR_W-2){1'b0}}, 2'b11};
  localparam logic [ADDR_W-1:0] PC_STEP    = {{(ADDR_W-3){1'b0}}, 3'b100};

  logic [1:0]             state_q, state_d;
  logic [ADDR_W-1:0]      fetch_pc_q, fetch_pc_d;
  logic [1:0][ADDR_W-1:0] fifo_pc_q, fifo_pc_d;
  logic [1:0][DATA_W-1:0] fifo_data_q, fifo_data_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;
  logic                   inflight_q, inflight_d;
  logic [ADDR_W-1:0]      inflight_pc_q, inflight_pc_d;

  logic              pop;
  logic              push;
  logic              issue;
  logic              enter_load;
  logic              wr_idx;
  logic [2:0]        occupancy;
  logic [ADDR_W-1:0] resume_pc;

  // A redirect landing in the same cycle as a response kills it by suppressing the push.
  assign pop        = (count_q != 2'd0) && inst_ready_i;
  assign push       = inflight_q && !redirect_valid_i;
  assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = (state_q == ST_FETCH) && !redirect_valid_i && !load_req_i &&
                      (occupancy < 3'd2) && !rst_i;
  assign enter_load = (state_q == ST_DRAIN) && load_req_i && !inflight_q;
  assign wr_idx     = rd_ptr_q ^ count_q[0];

  // Oldest instruction not yet handed downstream, after any transfer in this cycle.
  always_comb begin
    resume_pc = fetch_pc_q;
    if (count_q == 2'd2 || (count_q == 2'd1 && !pop)) begin
      resume_pc = pop ? fifo_pc_q[~rd_ptr_q] : fifo_pc_q[rd_ptr_q];
    end
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_data_d   = fifo_data_q;
    rd_ptr_d      = rd_ptr_q ^ pop;
    count_d       = count_q - {1'b0, pop} + {1'b0, push};
    inflight_d    = issue;
    inflight_pc_d = fetch_pc_q;

    case (state_q)
      ST_FETCH: if (load_req_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!load_req_i)      state_d = ST_FETCH;
        else if (!inflight_q) state_d = ST_LOAD;
      end
      ST_LOAD:  if (!load_req_i) state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase

    if (push) begin
      fifo_pc_d[wr_idx]   = inflight_pc_q;
      fifo_data_d[wr_idx] = mem_rdata_i;
    end

    if (redirect_valid_i || enter_load) count_d = 2'd0;

    if (redirect_valid_i)  fetch_pc_d = redirect_pc_i & ALIGN_MASK;
    else if (enter_load)   fetch_pc_d = resume_pc;
    else if (issue)        fetch_pc_d = fetch_pc_q + PC_STEP;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_FETCH;
      fetch_pc_q    <= RESET_PC;
      fifo_pc_q     <= '0;
      fifo_data_q   <= '0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      fifo_pc_q     <= fifo_pc_d;
      fifo_data_q   <= fifo_data_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // The FIFO is always empty in LOAD, so inst_valid drops without an explicit state term.
  assign inst_valid_o = (count_q != 2'd0);
  assign inst_pc_o    = fifo_pc_q[rd_ptr_q];
  assign inst_data_o  = fifo_data_q[rd_ptr_q];
  assign load_gnt_o   = (state_q == ST_LOAD) && !rst_i;
  assign mem_we_o     = load_gnt_o && load_req_i;
  assign mem_re_o     = issue;
  assign mem_addr_o   = (state_q == ST_LOAD) ? (load_addr_i & ALIGN_MASK) : fetch_pc_q;
  assign mem_wdata_o  = load_data_i;

endmodule
